// File: rtl/right_rotation.sv
// Right-side Jacobi rotation A*J on columns p and q (also used for V*J).
// Each row i of the two columns is pushed serially through a product stage and
// a sum stage. The final round, shift and saturate step is applied as the
// element is written into the result columns.
module right_rotation #(
    parameter int ACC_WIDTH = 32,
    parameter int N         = 4,
    parameter int FRAC_BITS = 14
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic signed [ACC_WIDTH-1:0] matrix_col_p     [N],
    input  logic signed [ACC_WIDTH-1:0] matrix_col_q     [N],
    input  logic signed [15:0]          sin_theta,
    input  logic signed [15:0]          cos_theta,
    output logic                        busy,
    output logic                        done,
    output logic                        sat_flag,
    output logic signed [ACC_WIDTH-1:0] matrix_col_p_new [N],
    output logic signed [ACC_WIDTH-1:0] matrix_col_q_new [N]
);

    // state | meaning
    // IDLE  | waiting for start; results hold their last values
    // RUN   | issuing one element per cycle into the product stage
    // DRAIN | all elements issued, waiting for the last write
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = ACC_WIDTH + 16;
    localparam int SW = ACC_WIDTH + 17;

    localparam logic signed [SW-1:0] ROUND_C =
        {{(SW-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};
    localparam logic signed [SW-1:0] SAT_MAX =
        {{(SW-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN =
        {{(SW-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [IW-1:0] LAST_IDX = IW'(N-1);

    state_t                      state_q;
    logic [IW-1:0]               idx_q;
    logic                        busy_q;
    logic                        done_q;
    logic                        sat_q;

    // Operand buffers so the caller may change inputs right after accept.
    logic signed [ACC_WIDTH-1:0] buf_p_q [N];
    logic signed [ACC_WIDTH-1:0] buf_q_q [N];
    logic signed [15:0]          cos_q;
    logic signed [15:0]          sin_q;

    // Pipeline valids and row tags.
    logic                        v1_q;
    logic                        v2_q;
    logic [IW-1:0]               idx1_q;
    logic [IW-1:0]               idx2_q;

    logic signed [PW-1:0]        prod_cp_q;
    logic signed [PW-1:0]        prod_sq_q;
    logic signed [PW-1:0]        prod_cq_q;
    logic signed [PW-1:0]        prod_sp_q;

    logic signed [SW-1:0]        sum_p_d;
    logic signed [SW-1:0]        sum_q_d;
    logic signed [SW-1:0]        sum_p_q;
    logic signed [SW-1:0]        sum_q_q;

    logic signed [SW-1:0]        rnd_p;
    logic signed [SW-1:0]        rnd_q;
    logic signed [ACC_WIDTH-1:0] res_p_d;
    logic signed [ACC_WIDTH-1:0] res_q_d;
    logic                        clip_p_d;
    logic                        clip_q_d;

    logic signed [ACC_WIDTH-1:0] out_p_q [N];
    logic signed [ACC_WIDTH-1:0] out_q_q [N];

    // Stage 2 combine: p' = c*p + s*q, q' = c*q - s*p, one guard bit wider.
    always_comb begin
        sum_p_d = SW'(prod_cp_q) + SW'(prod_sq_q);
        sum_q_d = SW'(prod_cq_q) - SW'(prod_sp_q);
    end

    // Round half up, drop the fraction bits, then clip to the element range.
    always_comb begin
        rnd_p    = (sum_p_q + ROUND_C) >>> FRAC_BITS;
        rnd_q    = (sum_q_q + ROUND_C) >>> FRAC_BITS;
        clip_p_d = 1'b0;
        clip_q_d = 1'b0;
        res_p_d  = rnd_p[ACC_WIDTH-1:0];
        res_q_d  = rnd_q[ACC_WIDTH-1:0];
        if (rnd_p > SAT_MAX) begin
            res_p_d  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
            clip_p_d = 1'b1;
        end else if (rnd_p < SAT_MIN) begin
            res_p_d  = {1'b1, {(ACC_WIDTH-1){1'b0}}};
            clip_p_d = 1'b1;
        end
        if (rnd_q > SAT_MAX) begin
            res_q_d  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
            clip_q_d = 1'b1;
        end else if (rnd_q < SAT_MIN) begin
            res_q_d  = {1'b1, {(ACC_WIDTH-1){1'b0}}};
            clip_q_d = 1'b1;
        end
    end

    // Arithmetic pipeline; the valid/tag bits that qualify it live in the FSM block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_cp_q <= '0;
            prod_sq_q <= '0;
            prod_cq_q <= '0;
            prod_sp_q <= '0;
            sum_p_q   <= '0;
            sum_q_q   <= '0;
        end else begin
            prod_cp_q <= PW'(cos_q) * PW'(buf_p_q[idx_q]);
            prod_sq_q <= PW'(sin_q) * PW'(buf_q_q[idx_q]);
            prod_cq_q <= PW'(cos_q) * PW'(buf_q_q[idx_q]);
            prod_sp_q <= PW'(sin_q) * PW'(buf_p_q[idx_q]);
            sum_p_q   <= sum_p_d;
            sum_q_q   <= sum_q_d;
        end
    end

    // Sequencing FSM with registered handshake outputs and result write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sat_q   <= 1'b0;
            cos_q   <= '0;
            sin_q   <= '0;
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            idx1_q  <= '0;
            idx2_q  <= '0;
            for (int i = 0; i < N; i++) begin
                buf_p_q[i] <= '0;
                buf_q_q[i] <= '0;
                out_p_q[i] <= '0;
                out_q_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            v1_q   <= (state_q == S_RUN);
            idx1_q <= idx_q;
            v2_q   <= v1_q;
            idx2_q <= idx1_q;

            if (v2_q) begin
                out_p_q[idx2_q] <= res_p_d;
                out_q_q[idx2_q] <= res_q_d;
                if (clip_p_d || clip_q_d) begin
                    sat_q <= 1'b1;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (start && !busy_q) begin
                        for (int i = 0; i < N; i++) begin
                            buf_p_q[i] <= matrix_col_p[i];
                            buf_q_q[i] <= matrix_col_q[i];
                        end
                        cos_q   <= cos_theta;
                        sin_q   <= sin_theta;
                        busy_q  <= 1'b1;
                        sat_q   <= 1'b0;
                        idx_q   <= '0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (idx_q == LAST_IDX) begin
                        state_q <= S_DRAIN;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (v2_q && (idx2_q == LAST_IDX)) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign sat_flag         = sat_q;
    assign matrix_col_p_new = out_p_q;
    assign matrix_col_q_new = out_q_q;

endmodule

// File: tb/tb_right_rotation.sv
module tb_right_rotation;

    localparam int N  = 4;
    localparam int AW = 32;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic signed [AW-1:0] col_p [N];
    logic signed [AW-1:0] col_q [N];
    logic signed [15:0]   sin_t;
    logic signed [15:0]   cos_t;
    logic                 busy;
    logic                 done;
    logic                 sat_flag;
    logic signed [AW-1:0] p_new [N];
    logic signed [AW-1:0] q_new [N];

    int n_vec;
    int n_miss;

    right_rotation #(.ACC_WIDTH(AW), .N(N), .FRAC_BITS(14)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .matrix_col_p     (col_p),
        .matrix_col_q     (col_q),
        .sin_theta        (sin_t),
        .cos_theta        (cos_t),
        .busy             (busy),
        .done             (done),
        .sat_flag         (sat_flag),
        .matrix_col_p_new (p_new),
        .matrix_col_q_new (q_new)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: real rotation arithmetic in 64-bit, round half up, clamp.
    function automatic void model(input int c, input int s, input int p[N], input int q[N],
                                  output int ep[N], output int eq[N], output bit esat);
        longint a;
        longint b;
        longint mx;
        longint mn;
        mx   = 64'sd2147483647;
        mn   = -64'sd2147483648;
        esat = 1'b0;
        for (int i = 0; i < N; i++) begin
            a = longint'(c) * longint'(p[i]) + longint'(s) * longint'(q[i]);
            b = longint'(c) * longint'(q[i]) - longint'(s) * longint'(p[i]);
            a = (a + 64'sd8192) >>> 14;
            b = (b + 64'sd8192) >>> 14;
            if (a > mx) begin a = mx; esat = 1'b1; end
            if (a < mn) begin a = mn; esat = 1'b1; end
            if (b > mx) begin b = mx; esat = 1'b1; end
            if (b < mn) begin b = mn; esat = 1'b1; end
            ep[i] = int'(a);
            eq[i] = int'(b);
        end
    endfunction

    task automatic drive(input int c, input int s, input int p[N], input int q[N]);
        cos_t = c[15:0];
        sin_t = s[15:0];
        for (int i = 0; i < N; i++) begin
            col_p[i] = p[i];
            col_q[i] = q[i];
        end
    endtask

    task automatic scramble();
        cos_t = 16'($urandom);
        sin_t = 16'($urandom);
        for (int i = 0; i < N; i++) begin
            col_p[i] = $urandom;
            col_q[i] = $urandom;
        end
    endtask

    // Runs one operation; reports edges from accept to done and busy cycles.
    task automatic do_op(input int c, input int s, input int p[N], input int q[N],
                         output int lat, output int busy_cyc);
        @(negedge clk);
        drive(c, s, p, q);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        scramble();
        lat      = 0;
        busy_cyc = busy ? 1 : 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) busy_cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        scramble();
        #12;
        n_vec++;
        if ({busy, done, sat_flag} !== 3'b000) begin
            n_miss++;
            $display("FAIL reset_ctrl got %b want 000", {busy, done, sat_flag});
        end
        for (int i = 0; i < N; i++) begin
            n_vec++;
            if (p_new[i] !== 0 || q_new[i] !== 0) begin
                n_miss++;
                $display("FAIL reset_out[%0d] got %0d/%0d want 0/0", i, p_new[i], q_new[i]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_identity();
        int p[N] = '{1, -2, 3, -4};
        int q[N] = '{5, 6, 7, 8};
        int lat, bc;
        do_op(16384, 0, p, q, lat, bc);
        n_vec++;
        if (lat !== N + 2) begin
            n_miss++;
            $display("FAIL ident_latency got %0d want %0d", lat, N + 2);
        end
        n_vec++;
        if (bc !== N + 2) begin
            n_miss++;
            $display("FAIL ident_busy_cycles got %0d want %0d", bc, N + 2);
        end
        n_vec++;
        if (busy !== 1'b0 || sat_flag !== 1'b0) begin
            n_miss++;
            $display("FAIL ident_busy_sat got %b%b want 00", busy, sat_flag);
        end
        for (int i = 0; i < N; i++) begin
            n_vec++;
            if (p_new[i] !== p[i] || q_new[i] !== q[i]) begin
                n_miss++;
                $display("FAIL ident_elem[%0d] got %0d/%0d want %0d/%0d", i, p_new[i], q_new[i], p[i], q[i]);
            end
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (done !== 1'b0) begin
            n_miss++;
            $display("FAIL ident_done_pulse got %b want 0", done);
        end
    endtask

    task automatic test_directed();
        int c[3] = '{0, 11585, 16384};
        int s[3] = '{16384, 11585, 16384};
        int p[N];
        int q[N];
        int ep[N];
        int eq[N];
        int wp[N];
        int wq[N];
        bit esat;
        int lat, bc;
        for (int t = 0; t < 3; t++) begin
            case (t)
                0: begin p = '{1, -2, 3, -4}; q = '{5, 6, 7, 8};
                         wp = '{5, 6, 7, 8}; wq = '{-1, 2, -3, 4}; end
                1: begin p = '{10000, 0, -10000, 1}; q = '{0, 0, 0, 0};
                         wp = '{7071, 0, -7071, 1}; wq = '{-7071, 0, 7071, -1}; end
                default: begin p = '{4{32'sh7fffffff}}; q = '{4{32'sh7fffffff}};
                         wp = '{4{32'sh7fffffff}}; wq = '{0, 0, 0, 0}; end
            endcase
            model(c[t], s[t], p, q, ep, eq, esat);
            do_op(c[t], s[t], p, q, lat, bc);
            n_vec++;
            if (lat !== N + 2) begin
                n_miss++;
                $display("FAIL dir%0d_latency got %0d want %0d", t, lat, N + 2);
            end
            for (int i = 0; i < N; i++) begin
                n_vec++;
                if (p_new[i] !== wp[i] || q_new[i] !== wq[i] || ep[i] !== wp[i] || eq[i] !== wq[i]) begin
                    n_miss++;
                    $display("FAIL dir%0d_elem[%0d] got %0d/%0d want %0d/%0d", t, i, p_new[i], q_new[i], wp[i], wq[i]);
                end
            end
            n_vec++;
            if (sat_flag !== (t == 2)) begin
                n_miss++;
                $display("FAIL dir%0d_sat got %b want %b", t, sat_flag, t == 2);
            end
        end
    endtask

    task automatic test_sat_clear();
        int p[N] = '{9, 8, 7, 6};
        int q[N] = '{-1, -2, -3, -4};
        int lat, bc;
        do_op(16384, 0, p, q, lat, bc);
        n_vec++;
        if (sat_flag !== 1'b0 || p_new[0] !== 9) begin
            n_miss++;
            $display("FAIL sat_clear got sat=%b p0=%0d want sat=0 p0=9", sat_flag, p_new[0]);
        end
    endtask

    task automatic test_random();
        int p[N];
        int q[N];
        int ep[N];
        int eq[N];
        bit esat;
        int c, s, lat, bc;
        for (int t = 0; t < 10; t++) begin
            c = $urandom_range(0, 65535) - 32768;
            s = $urandom_range(0, 65535) - 32768;
            for (int i = 0; i < N; i++) begin
                p[i] = $urandom;
                q[i] = $urandom;
                if (t < 8) begin
                    p[i] = p[i] >>> (t * 4);
                    q[i] = q[i] >>> (t * 4);
                end
            end
            if (t == 0) begin
                c = -32768; s = -32768;
                p = '{4{32'sh80000000}};
                q = '{4{32'sh80000000}};
            end
            if (t == 1) begin c = 0; s = 0; end
            model(c, s, p, q, ep, eq, esat);
            do_op(c, s, p, q, lat, bc);
            n_vec++;
            if (lat !== N + 2) begin
                n_miss++;
                $display("FAIL rnd%0d_latency got %0d want %0d", t, lat, N + 2);
            end
            for (int i = 0; i < N; i++) begin
                n_vec++;
                if (p_new[i] !== ep[i] || q_new[i] !== eq[i]) begin
                    n_miss++;
                    $display("FAIL rnd%0d_elem[%0d] got %0d/%0d want %0d/%0d", t, i, p_new[i], q_new[i], ep[i], eq[i]);
                end
            end
            n_vec++;
            if (sat_flag !== esat) begin
                n_miss++;
                $display("FAIL rnd%0d_sat got %b want %b", t, sat_flag, esat);
            end
        end
    endtask

    task automatic test_back_to_back();
        int p[N] = '{100, 200, 300, 400};
        int q[N] = '{-5, -6, -7, -8};
        int ep[N];
        int eq[N];
        bit esat;
        int dones, k;
        // A start pulse while busy must be dropped.
        @(negedge clk);
        drive(16384, 0, p, q);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        n_vec++;
        if (dones !== 1) begin
            n_miss++;
            $display("FAIL busy_start_ignored got %0d dones want 1", dones);
        end
        // Start held through the done cycle restarts on the next edge.
        model(11585, -11585, p, q, ep, eq, esat);
        @(negedge clk);
        drive(11585, -11585, p, q);
        start = 1'b1;
        k = 0;
        while (!done && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_vec++;
        if (k !== N + 3) begin
            n_miss++;
            $display("FAIL b2b_first_done got %0d edges want %0d", k, N + 3);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin
            n_miss++;
            $display("FAIL b2b_reaccept got busy=%b want 1", busy);
        end
        k = 1;
        while (!done && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_vec++;
        if (k !== N + 3) begin
            n_miss++;
            $display("FAIL b2b_spacing got %0d want %0d", k, N + 3);
        end
        for (int i = 0; i < N; i++) begin
            n_vec++;
            if (p_new[i] !== ep[i] || q_new[i] !== eq[i]) begin
                n_miss++;
                $display("FAIL b2b_elem[%0d] got %0d/%0d want %0d/%0d", i, p_new[i], q_new[i], ep[i], eq[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int p[N] = '{11, 22, 33, 44};
        int q[N] = '{1, 2, 3, 4};
        int ep[N];
        int eq[N];
        bit esat;
        int dones, lat, bc;
        @(negedge clk);
        drive(0, 16384, p, q);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({busy, done, sat_flag} !== 3'b000) begin
            n_miss++;
            $display("FAIL midrst_ctrl got %b want 000", {busy, done, sat_flag});
        end
        for (int i = 0; i < N; i++) begin
            n_vec++;
            if (p_new[i] !== 0 || q_new[i] !== 0) begin
                n_miss++;
                $display("FAIL midrst_out[%0d] got %0d/%0d want 0/0", i, p_new[i], q_new[i]);
            end
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) dones++;
        end
        n_vec++;
        if (dones !== 0) begin
            n_miss++;
            $display("FAIL midrst_no_done got %0d active cycles want 0", dones);
        end
        model(0, 16384, p, q, ep, eq, esat);
        do_op(0, 16384, p, q, lat, bc);
        n_vec++;
        if (lat !== N + 2) begin
            n_miss++;
            $display("FAIL midrst_restart_latency got %0d want %0d", lat, N + 2);
        end
        for (int i = 0; i < N; i++) begin
            n_vec++;
            if (p_new[i] !== ep[i] || q_new[i] !== eq[i]) begin
                n_miss++;
                $display("FAIL midrst_elem[%0d] got %0d/%0d want %0d/%0d", i, p_new[i], q_new[i], ep[i], eq[i]);
            end
        end
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        test_reset();
        test_identity();
        test_directed();
        test_sat_clear();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
